// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (start, 8 data bits LSB first, [parity], stop).
// Define UART_TX_PARITY_EN to insert the even-parity bit; without it frames are 10 bits long.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Full,
  output logic       o_Empty,
  output logic       o_Overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;

  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_tx_serial;
  logic             r_tx_active;
  logic             r_tx_done;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W:0]   w_count_next;
  state_t           w_state_next;
  logic [CNT_W-1:0] w_clk_cnt_next;
  logic [2:0]       w_bit_idx_next;
  logic [2:0]       w_idx_inc;
  logic [7:0]       w_shift_next;
  logic             w_parity_next;
  logic             w_serial_next;
  logic             w_done_next;
  logic             w_bit_end;

  // Full is the registered flag, so a same-cycle pop never admits a write while full.
  assign w_push = i_Tx_DV && !r_full;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
      2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is tracked by pointers and count,
  // so clearing the data would only add reset fan-out.
  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_Tx_Byte;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_next;
      r_full     <= (w_count_next == (PTR_W+1)'(FIFO_DEPTH));
      r_empty    <= (w_count_next == '0);
      r_overflow <= i_Tx_DV && r_full;
    end
  end

  assign w_bit_end = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_idx_inc = r_bit_idx + 3'd1;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_serial_next  = r_tx_serial;
    w_done_next    = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_serial_next  = 1'b1;
        w_clk_cnt_next = '0;
        if (!r_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = r_mem[r_rd_ptr];
          w_parity_next = ^r_mem[r_rd_ptr];
          w_serial_next = 1'b0;
          w_state_next  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = 3'd0;
          w_serial_next  = r_shift[0];
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_serial_next = r_parity;
            w_state_next  = S_PARITY;
`else
            w_serial_next = 1'b1;
            w_state_next  = S_STOP;
`endif
          end else begin
            w_bit_idx_next = w_idx_inc;
            w_serial_next  = r_shift[w_idx_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_serial_next  = 1'b1;
          w_state_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_next = '0;
          w_serial_next  = 1'b1;
          w_done_next    = 1'b1;
          w_state_next   = S_IDLE;
        end
      end
      default: begin
        w_clk_cnt_next = '0;
        w_serial_next  = 1'b1;
        w_state_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_parity    <= 1'b0;
      r_tx_serial <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clk_cnt   <= w_clk_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_parity    <= w_parity_next;
      r_tx_serial <= w_serial_next;
      r_tx_active <= (w_state_next != S_IDLE);
      r_tx_done   <= w_done_next;
    end
  end

  assign o_Tx_Serial = r_tx_serial;
  assign o_Tx_Active = r_tx_active;
  assign o_Tx_Done   = r_tx_done;
  assign o_Full      = r_full;
  assign o_Empty     = r_empty;
  assign o_Overflow  = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a byte scoreboard and a line sampler.
// Frame length follows UART_TX_PARITY_EN (11 bits when defined, 10 otherwise).
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] tx_byte;
  logic       serial, active, done, full, empty, overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] sb[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Tx_DV    (dv),
    .i_Tx_Byte  (tx_byte),
    .o_Tx_Serial(serial),
    .o_Tx_Active(active),
    .o_Tx_Done  (done),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic wr(input logic [7:0] b, input bit accept);
    @(negedge clk);
    dv      = 1'b1;
    tx_byte = b;
    if (accept) sb.push_back(b);
  endtask

  task automatic wr_end(output int w_cyc);
    @(negedge clk);
    dv    = 1'b0;
    w_cyc = cyc;
  endtask

  // Samples one frame at bit centres; start_cyc/done_cyc are edge counts of start and Tx_Done.
  task automatic rx_frame(input string tag, output logic [10:0] frame,
                          output int start_cyc, output int done_cyc);
    bit seen;
    seen      = 1'b0;
    frame     = '1;
    start_cyc = 0;
    done_cyc  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (serial === 1'b0) seen = 1'b1;
    end
    check({tag, " start_seen"}, 16'(seen), 16'(1));
    if (!seen) return;
    start_cyc = cyc;
    repeat (2) @(negedge clk);
    frame[0] = serial;
    check({tag, " active_in_frame"}, 16'(active), 16'(1));
    for (int k = 1; k < NBITS; k++) begin
      repeat (CPB) @(negedge clk);
      frame[k] = serial;
    end
    @(negedge clk);
    check({tag, " done_early"}, 16'(done), 16'(0));
    @(negedge clk);
    done_cyc = cyc;
    check({tag, " done_pulse"}, 16'(done), 16'(1));
    check({tag, " idle_gap_high"}, 16'(serial), 16'(1));
    check({tag, " active_after"}, 16'(active), 16'(0));
    check({tag, " done_latency"}, 16'(done_cyc - start_cyc), 16'(NBITS * CPB));
  endtask

  task automatic rx_cmp(input string tag, output logic [10:0] frame,
                        output int start_cyc, output int done_cyc);
    logic [7:0] exp_b;
    rx_frame(tag, frame, start_cyc, done_cyc);
    check({tag, " sb_nonempty"}, 16'(sb.size() > 0), 16'(1));
    exp_b = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    check({tag, " frame"}, 16'(frame), 16'(frame_of(exp_b)));
  endtask

  initial begin
    logic [10:0] f;
    int s1, s2, s3, d1, d2, d3, w_cyc;
    bit bad;

    rst = 1'b1; dv = 1'b0; tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst serial", 16'(serial), 16'(1));
    check("rst active", 16'(active), 16'(0));
    check("rst done", 16'(done), 16'(0));
    check("rst overflow", 16'(overflow), 16'(0));
    check("rst full", 16'(full), 16'(0));
    check("rst empty", 16'(empty), 16'(1));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: start edge one cycle after the write edge.
    wr(8'hC9, 1'b1);
    fork
      begin
        wr_end(w_cyc);
        check("single empty_after_write", 16'(empty), 16'(0));
      end
      rx_cmp("single", f, s1, d1);
    join
    check("single start_latency", 16'(s1 - w_cyc), 16'(1));
    check("single frame_literal", 16'(f[NBITS-1:0]),
          16'((NBITS == 11) ? 11'b101_1001_0010 : 11'b11_1001_0010));
    check("single empty_after", 16'(empty), 16'(1));

    // Parity value for two bytes of odd and even weight.
    wr(8'h07, 1'b1);
    fork
      wr_end(w_cyc);
      rx_cmp("par07", f, s1, d1);
    join
`ifdef UART_TX_PARITY_EN
    check("par07 parity_bit", 16'(f[9]), 16'(1));
`endif
    wr(8'h05, 1'b1);
    fork
      wr_end(w_cyc);
      rx_cmp("par05", f, s1, d1);
    join
`ifdef UART_TX_PARITY_EN
    check("par05 parity_bit", 16'(f[9]), 16'(0));
`endif

    // Back-to-back frames: one idle cycle between frames.
    fork
      begin
        wr(8'hC9, 1'b1);
        wr(8'h05, 1'b1);
        wr(8'hC9, 1'b1);
        wr_end(w_cyc);
      end
      begin
        rx_cmp("b2b0", f, s1, d1);
        rx_cmp("b2b1", f, s2, d2);
        rx_cmp("b2b2", f, s3, d3);
      end
    join
    check("b2b done_spacing01", 16'(d2 - d1), 16'(NBITS * CPB + 1));
    check("b2b done_spacing12", 16'(d3 - d2), 16'(NBITS * CPB + 1));
    check("b2b start_after_done", 16'(s2 - d1), 16'(1));

    // Overflow: first byte popped during the second write, sixth write dropped.
    fork
      begin
        wr(8'h01, 1'b1);
        wr(8'h02, 1'b1);
        wr(8'h03, 1'b1);
        wr(8'h04, 1'b1);
        wr(8'h05, 1'b1);
        wr(8'h06, 1'b0);
        check("ovf full_after_5", 16'(full), 16'(1));
        check("ovf no_early_pulse", 16'(overflow), 16'(0));
        wr_end(w_cyc);
        check("ovf pulse", 16'(overflow), 16'(1));
        @(negedge clk);
        check("ovf pulse_one_cycle", 16'(overflow), 16'(0));
      end
      begin
        rx_cmp("ovf0", f, s1, d1);
        rx_cmp("ovf1", f, s1, d1);
        rx_cmp("ovf2", f, s1, d1);
        rx_cmp("ovf3", f, s1, d1);
        rx_cmp("ovf4", f, s1, d1);
      end
    join
    check("ovf sb_drained", 16'(sb.size()), 16'(0));
    check("ovf empty_after", 16'(empty), 16'(1));

    // Reset during DATA of 0xA5 with two bytes still queued.
    wr(8'hA5, 1'b0);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr_end(w_cyc);
    repeat (8) @(negedge clk);
    check("rstmid in_frame", 16'(active), 16'(1));
    check("rstmid queued", 16'(empty), 16'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid serial_high", 16'(serial), 16'(1));
    check("rstmid empty", 16'(empty), 16'(1));
    check("rstmid active", 16'(active), 16'(0));
    check("rstmid full", 16'(full), 16'(0));
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || serial !== 1'b1) bad = 1'b1;
    end
    check("rstmid quiet_line", 16'(bad), 16'(0));

    // Normal operation resumes after the reset.
    wr(8'h5A, 1'b1);
    fork
      wr_end(w_cyc);
      rx_cmp("post_rst", f, s1, d1);
    join
    check("post_rst empty_after", 16'(empty), 16'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter downstream of `DMA_controller_IO`. It accepts bytes on the DMA's `o_uart_tx` / `o_uart_tx_dv` strobe into a small FIFO and serialises each byte onto the TX line. The frame format is the one `uart_rx_fifo` expects: start, 8 data bits LSB first, even parity, stop. It reports completion per frame on `o_Tx_Done`, which feeds the DMA's `i_Tx_Done`.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte entries; must be a power of 2, ≥ 2.
- `i_Clock`  in  1: single clock; all logic on its rising edge.
- `i_Reset`  in  1: reset, synchronous and active-high.
- `i_Tx_DV`  in  1: one-cycle write strobe for `i_Tx_Byte`.
- `i_Tx_Byte`  in  8: byte to enqueue.
- `o_Tx_Serial`  out  1: serial line; idles high.
- `o_Tx_Active`  out  1: high while a frame is on the line (START through STOP).
- `o_Tx_Done`  out  1: one-cycle pulse at the end of each frame's stop bit.
- `o_Full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `o_Empty`  out  1: FIFO holds 0 entries.
- `o_Overflow`  out  1: one-cycle pulse when a write is dropped.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers of width `$clog2(FIFO_DEPTH)`. Pointers wrap naturally.
  - Count register is one bit wider than the pointers.
- **Write**
  - `i_Tx_DV=1` and `o_Full=0`: byte stored at the write pointer, pointer and count increment.
  - `i_Tx_DV=1` and `o_Full=1`: byte dropped; `o_Overflow` pulses on the next cycle.
  - `o_Full` is evaluated on the current count. A pop in the same cycle does not admit a write while full.
- **Simultaneous push and pop:** both pointers advance and the count is unchanged.
- **State machine**
  - IDLE: line high. If `o_Empty=0`, load the head byte into the shift register, pop, compute parity, go to START.
  - START: line 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: line carries `shift[index]` for `CLKS_PER_BIT` cycles each. Index 0..7; after index 7 go to PARITY.
  - PARITY: line carries XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: line 1 for `CLKS_PER_BIT` cycles, then pulse `o_Tx_Done` and go to IDLE.
- The bit-cycle counter runs 0..`CLKS_PER_BIT`-1 and clears on each bit transition.
- `o_Tx_Active` is 1 in START, DATA, PARITY and STOP.
- **Reset values**
  - `o_Tx_Serial`=1; `o_Tx_Active`, `o_Tx_Done`, `o_Overflow`, `o_Full` = 0; `o_Empty`=1.
  - Pointers and count = 0; state = IDLE.
- **Reset mid-frame:** the frame is aborted, the line returns high on the next edge, no `o_Tx_Done` pulse is issued, and FIFO contents are discarded.

## Timing
- All outputs are registered.
- A write at edge W is visible as `o_Empty=0` after W. With the TX engine idle, the pop happens at edge W+1 and `o_Tx_Serial` falls at W+1.
- Frame length with parity: 11×`CLKS_PER_BIT` cycles from the start-bit falling edge T. `o_Tx_Done` is high for the cycle starting at T+11×`CLKS_PER_BIT`.
- Back-to-back frames leave exactly one IDLE cycle (line high) between stop bit and next start bit. The next start edge is T+11×`CLKS_PER_BIT`+1.
- Writes are accepted every cycle, independent of the TX engine state.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state is present. Frames are 11 bits and match `uart_rx_fifo`.
- **`UART_TX_PARITY_EN` undefined:** the PARITY state is removed and DATA goes directly to STOP.
  - Frames are 10 bits; `o_Tx_Done` fires at T+10×`CLKS_PER_BIT`.
  - All other behaviour is unchanged.

## Test plan
All scenarios use `CLKS_PER_BIT=4`, `FIFO_DEPTH=4`, with `UART_TX_PARITY_EN` defined unless stated otherwise.
- **Single byte:** write 0xC9 → line samples at bit centres read 0,1,0,0,1,0,0,1,1,0(parity),1. `o_Tx_Done` pulses 44 cycles after the start edge; `o_Empty`=1 afterwards.
- **Parity value:** write 0x07 → parity bit is 1. Write 0x05 → parity bit is 0.
- **Back-to-back:** write 0xC9, 0x05, 0xC9 on consecutive cycles → three frames with a 1-cycle high gap between them, three `o_Tx_Done` pulses 45 cycles apart, byte order preserved.
- **Overflow:** 6 writes (0x01..0x06) on consecutive cycles from idle →
  - the first byte is popped at write 2, so 0x01..0x05 are accepted;
  - 0x06 is dropped with one `o_Overflow` pulse;
  - `o_Full`=1 after the 5th write;
  - frames 0x01..0x05 are sent in order.
- **Reset mid-frame:** assert `i_Reset` for 1 cycle during DATA of 0xA5 with 2 bytes still queued → the line is high the next cycle, all FIFO contents are discarded, `o_Empty`=1, and no `o_Tx_Done` pulse occurs.
- **Parity disabled:** with `UART_TX_PARITY_EN` undefined, write 0xC9 → 10-bit frame; `o_Tx_Done` pulses 40 cycles after the start edge.
